// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetcher feeding a small in-order buffer.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  fetch buffer entries (2 or 4)
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   imem_req/addr/gnt           instruction memory request channel
//   imem_rvalid/rdata           instruction memory response channel
//   if_valid/if_instr/if_pc     buffer head towards decode
//   id_ready                    decode consumes the head
//   redirect/redirect_pc        flush and refetch from a new PC
// Optional (macro IFU_PERF_EN):
//   fetch_cnt                   pops accepted by decode
//   stall_cnt                   cycles with an empty buffer and no redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StReq, StWait, StDrain, StFull} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [31:0]       pc_mem_q    [FIFO_DEPTH];
  logic [31:0]       instr_mem_q [FIFO_DEPTH];
  logic              push, pop;
  logic              unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A redirect suppresses both the incoming response and any same-cycle pop.
  assign push = (state_q == StWait) & imem_rvalid & ~redirect;
  assign pop  = (count_q != '0) & id_ready & ~redirect;

  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      if (push) count_d = count_d + CntW'(1);
      if (pop)  count_d = count_d - CntW'(1);
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq: begin
        if (redirect)      state_d = imem_gnt ? StDrain : StReq;
        else if (imem_gnt) state_d = StWait;
      end
      StWait: begin
        if (redirect)         state_d = imem_rvalid ? StReq : StDrain;
        else if (imem_rvalid) state_d = (count_d < Depth) ? StReq : StFull;
      end
      // The stale response is consumed here; a redirect only retargets fetch_pc.
      StDrain: begin
        if (imem_rvalid) state_d = StReq;
      end
      StFull: begin
        if (redirect || pop) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req  = (state_q == StReq);
    imem_addr = fetch_pc_q;
    if_valid  = (count_q != '0);
    if_instr  = if_valid ? instr_mem_q[rd_ptr_q] : '0;
    if_pc     = if_valid ? pc_mem_q[rd_ptr_q]    : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Buffer storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop)                    fetch_cnt <= fetch_cnt + 32'd1;
      if (!if_valid && !redirect) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC  (RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .id_ready   (id_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
`ifdef IFU_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: buffer contents, fetch PC, requests in flight and responses to discard.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_inflight, m_drop, m_pops, m_stalls, rv_count;
  bit          mem_pend;
  logic [31:0] mem_addr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_check();
    bit   exp_req;
    ent_t h;
    exp_req = (m_inflight == 0) && (m_drop == 0) && (mq.size() < DEPTH);
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
    chk("if_pc", if_pc, h.pc);
    chk("if_instr", if_instr, h.instr);
  endtask

  // One clock: check at negedge, drive inputs, advance model and memory, wait next negedge.
  task automatic cycle(input bit g, input bit rv_en, input bit rdy, input bit rd,
                       input logic [31:0] rpc);
    bit          exp_req, rv, pop;
    logic [31:0] data;
    ent_t        e;
    model_check();
    exp_req = (m_inflight == 0) && (m_drop == 0) && (mq.size() < DEPTH);
    rv   = mem_pend && rv_en;
    data = rv ? word_at(mem_addr) : $urandom;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = data;
    id_ready = rdy; redirect = rd; redirect_pc = rpc;
    if (rv) begin
      mem_pend = 1'b0;
      rv_count++;
    end
    if (imem_req && g) begin
      mem_pend = 1'b1;
      mem_addr = imem_addr;
    end
    pop = (mq.size() > 0) && rdy && !rd;
    if (mq.size() == 0 && !rd) m_stalls++;
    if (pop) begin
      m_pops++;
      void'(mq.pop_front());
    end
    if (rv) begin
      if (m_drop > 0) begin
        m_drop--;
      end else begin
        m_inflight--;
        if (!rd) begin
          e.pc = m_pc; e.instr = data;
          mq.push_back(e);
          m_pc += 32'd4;
        end
      end
    end
    if (exp_req && g) m_inflight++;
    if (rd) begin
      m_drop += m_inflight;
      m_inflight = 0;
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end
    @(negedge clk);
  endtask

  task automatic perf_check();
`ifdef IFU_PERF_EN
    chk("fetch_cnt", fetch_cnt, 32'(m_pops));
    chk("stall_cnt", stall_cnt, 32'(m_stalls));
`endif
  endtask

  // Asserts reset between clock edges and checks it takes effect without a clock.
  task automatic do_reset();
    reset = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    mq.delete();
    m_pc = RPC; m_inflight = 0; m_drop = 0; m_pops = 0; m_stalls = 0;
    mem_pend = 1'b0; rv_count = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [31:0] gnt, rv, rdata, rdy, rd, rpc;
    logic [31:0] e_req, e_addr, e_val, e_pc, e_instr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] gnt, rv, rdata, rdy, rd, rpc,
                              input logic [31:0] e_req, e_addr, e_val, e_pc, e_instr);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  initial begin
    vec_t        tbl[16];
    logic [31:0] a0, a1, a2, stale, b0, b1;
    a0 = 32'hA000_0013; a1 = 32'hA111_0033; a2 = 32'hA222_0063;
    stale = 32'hDEAD_006F; b0 = 32'hB000_0093; b1 = 32'hB111_00B3;
    //            gnt rv rdata rdy rd rpc         req addr       val pc         instr
    tbl[0]  = mk(1, 0, 0,     1, 0, 0,           1, 0,          0, 0,         0);
    tbl[1]  = mk(0, 1, a0,    1, 0, 0,           0, 0,          0, 0,         0);
    tbl[2]  = mk(1, 0, 0,     1, 0, 0,           1, 4,          1, 0,         a0);
    tbl[3]  = mk(0, 1, a1,    1, 0, 0,           0, 0,          0, 0,         0);
    tbl[4]  = mk(1, 0, 0,     1, 0, 0,           1, 8,          1, 4,         a1);
    tbl[5]  = mk(0, 1, a2,    1, 0, 0,           0, 0,          0, 0,         0);
    tbl[6]  = mk(1, 0, 0,     1, 0, 0,           1, 32'hC,      1, 8,         a2);
    tbl[7]  = mk(0, 0, 0,     1, 1, 32'h103,     0, 0,          0, 0,         0);
    tbl[8]  = mk(0, 1, stale, 1, 0, 0,           0, 0,          0, 0,         0);
    tbl[9]  = mk(1, 0, 0,     1, 0, 0,           1, 32'h100,    0, 0,         0);
    tbl[10] = mk(0, 1, b0,    0, 0, 0,           0, 0,          0, 0,         0);
    tbl[11] = mk(1, 0, 0,     0, 0, 0,           1, 32'h104,    1, 32'h100,   b0);
    tbl[12] = mk(0, 1, b1,    1, 1, 32'h200,     0, 0,          1, 32'h100,   b0);
    tbl[13] = mk(0, 0, 0,     1, 0, 0,           1, 32'h200,    0, 0,         0);
    tbl[14] = mk(0, 0, 0,     1, 1, 32'h304,     1, 32'h200,    0, 0,         0);
    tbl[15] = mk(0, 0, 0,     1, 0, 0,           1, 32'h304,    0, 0,         0);

    reset = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("vec%0d_req", i), 32'(imem_req), tbl[i].e_req);
      if (tbl[i].e_req[0]) chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), tbl[i].e_val);
      chk($sformatf("vec%0d_pc", i), if_pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), if_instr, tbl[i].e_instr);
      imem_gnt = tbl[i].gnt[0]; imem_rvalid = tbl[i].rv[0]; imem_rdata = tbl[i].rdata;
      id_ready = tbl[i].rdy[0]; redirect = tbl[i].rd[0]; redirect_pc = tbl[i].rpc;
      @(negedge clk);
    end

    // Buffer fills with decode stalled, then drains in order and fetching resumes.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("full_pushes", 32'(rv_count), 32'(DEPTH));
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(if_valid), 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    chk("resume_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    perf_check();

    // Fetch address wraps past the top of the address space.
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("wrap_req", 32'(imem_req), 32'd1);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    perf_check();

    // Random traffic against the model, with resets landing mid-transaction.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] rpc;
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
      end
      perf_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
